// File: rtl/prog_loader_if.sv
// Signal bundle between the host-side loader, the host byte streams,
// the processor control pins and the instruction/data memory ports.
interface prog_loader_if;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_ready;
  logic       proc_en;
  logic       proc_finish;
  logic       im_we;
  logic [7:0] im_waddr;
  logic [7:0] im_wdata;
  logic       dm_sel;
  logic       dm_we;
  logic [7:0] dm_addr;
  logic [7:0] dm_wdata;
  logic [7:0] dm_rdata;

  // Loader side.
  modport slave (
    input  in_valid, in_data, out_ready, proc_finish, dm_rdata,
    output in_ready, out_valid, out_data, proc_en,
           im_we, im_waddr, im_wdata, dm_sel, dm_we, dm_addr, dm_wdata
  );

  // Host, processor and memory side.
  modport master (
    output in_valid, in_data, out_ready, proc_finish, dm_rdata,
    input  in_ready, out_valid, out_data, proc_en,
           im_we, im_waddr, im_wdata, dm_sel, dm_we, dm_addr, dm_wdata
  );
endinterface

// File: rtl/prog_loader.sv
// Load/run/dump controller: streams an instruction and data image into memory,
// runs the core under a watchdog, then returns a status byte and a DM window.
module prog_loader #(
  parameter logic [15:0] RUN_TIMEOUT = 16'hFFFF
) (
  input logic          CLOCK,
  input logic          RESETN,
  prog_loader_if.slave bus
);

  typedef enum logic [3:0] {
    S_IDLE, S_LOAD_IM, S_DM_LEN, S_LOAD_DM, S_DUMP_LEN,
    S_RUN, S_STATUS, S_DUMP_RD, S_DUMP_OUT
  } state_e;

  state_e      r_state;
  state_e      w_next;

  logic [7:0]  r_len;
  logic [7:0]  r_addr;
  logic [7:0]  r_dump_len;
  logic [15:0] r_run_cnt;
  logic        r_out_valid;
  logic [7:0]  r_out_data;
  logic        r_im_we;
  logic [7:0]  r_im_waddr;
  logic [7:0]  r_im_wdata;
  logic        r_dm_we;
  logic [7:0]  r_dm_addr;
  logic [7:0]  r_dm_wdata;

  logic        w_in_ready;
  logic        w_proc_en;
  logic        w_accept;
  logic        w_out_take;
  logic        w_timeout;
  logic        w_last_load;
  logic        w_last_dump;

  assign w_accept    = bus.in_valid & w_in_ready;
  assign w_out_take  = r_out_valid & bus.out_ready;
  assign w_timeout   = (r_run_cnt + 16'd1) == RUN_TIMEOUT;
  assign w_last_load = ({1'b0, r_addr} + 9'd1) == {1'b0, r_len};
  assign w_last_dump = ({1'b0, r_addr} + 9'd1) == {1'b0, r_dump_len};

  // State register.
  always_ff @(posedge CLOCK or negedge RESETN) begin
    if (!RESETN) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  // Next-state logic.
  always_comb begin
    // NOTE: default first so every path assigns w_next and no latch is inferred.
    w_next = r_state;
    case (r_state)
      S_IDLE:     if (w_accept) w_next = (bus.in_data == 8'd0) ? S_DM_LEN : S_LOAD_IM;
      S_LOAD_IM:  if (w_accept && w_last_load) w_next = S_DM_LEN;
      S_DM_LEN:   if (w_accept) w_next = (bus.in_data == 8'd0) ? S_DUMP_LEN : S_LOAD_DM;
      S_LOAD_DM:  if (w_accept && w_last_load) w_next = S_DUMP_LEN;
      S_DUMP_LEN: if (w_accept) w_next = S_RUN;
      S_RUN:      if (bus.proc_finish || w_timeout) w_next = S_STATUS;
      S_STATUS:
        if (w_out_take)
          w_next = (r_out_data == 8'h00 && r_dump_len != 8'd0) ? S_DUMP_RD : S_IDLE;
      S_DUMP_RD:  w_next = S_DUMP_OUT;
      S_DUMP_OUT: if (w_out_take) w_next = w_last_dump ? S_IDLE : S_DUMP_RD;
      default:    w_next = S_IDLE;
    endcase
  end

  // State-decoded outputs.
  always_comb begin
    w_in_ready = 1'b0;
    w_proc_en  = 1'b0;
    case (r_state)
      S_IDLE, S_LOAD_IM, S_DM_LEN, S_LOAD_DM, S_DUMP_LEN: w_in_ready = 1'b1;
      S_RUN:   w_proc_en = 1'b1;
      default: ;
    endcase
  end

  // Counters, memory write strobes and the result byte register.
  always_ff @(posedge CLOCK or negedge RESETN) begin
    if (!RESETN) begin
      r_len       <= 8'd0;
      r_addr      <= 8'd0;
      r_dump_len  <= 8'd0;
      r_run_cnt   <= 16'd0;
      r_out_valid <= 1'b0;
      r_out_data  <= 8'h00;
      r_im_we     <= 1'b0;
      r_im_waddr  <= 8'd0;
      r_im_wdata  <= 8'd0;
      r_dm_we     <= 1'b0;
      r_dm_addr   <= 8'd0;
      r_dm_wdata  <= 8'd0;
    end else begin
      // NOTE: non-blocking throughout so every read sees the pre-edge value.
      r_im_we <= 1'b0;
      r_dm_we <= 1'b0;
      case (r_state)
        S_IDLE, S_DM_LEN:
          if (w_accept) begin
            r_len  <= bus.in_data;
            r_addr <= 8'd0;
          end
        S_LOAD_IM:
          if (w_accept) begin
            r_im_we    <= 1'b1;
            r_im_waddr <= r_addr;
            r_im_wdata <= bus.in_data;
            r_addr     <= r_addr + 8'd1;
          end
        S_LOAD_DM:
          if (w_accept) begin
            r_dm_we    <= 1'b1;
            r_dm_addr  <= r_addr;
            r_dm_wdata <= bus.in_data;
            r_addr     <= r_addr + 8'd1;
          end
        S_DUMP_LEN:
          if (w_accept) begin
            r_dump_len <= bus.in_data;
            r_run_cnt  <= 16'd0;
          end
        S_RUN: begin
          r_run_cnt <= r_run_cnt + 16'd1;
          // Finish takes priority over a coincident watchdog expiry.
          if (bus.proc_finish || w_timeout) begin
            r_out_valid <= 1'b1;
            r_out_data  <= bus.proc_finish ? 8'h00 : 8'hEE;
          end
        end
        S_STATUS:
          if (w_out_take) begin
            r_out_valid <= 1'b0;
            r_addr      <= 8'd0;
            r_dm_addr   <= 8'd0;
          end
        S_DUMP_OUT:
          // First cycle captures the read data, then hold until consumed.
          if (!r_out_valid) begin
            r_out_valid <= 1'b1;
            r_out_data  <= bus.dm_rdata;
          end else if (bus.out_ready) begin
            r_out_valid <= 1'b0;
            r_addr      <= r_addr + 8'd1;
            r_dm_addr   <= r_addr + 8'd1;
          end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.proc_en   = w_proc_en;
  assign bus.dm_sel    = ~w_proc_en;
  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_out_data;
  assign bus.im_we     = r_im_we;
  assign bus.im_waddr  = r_im_waddr;
  assign bus.im_wdata  = r_im_wdata;
  assign bus.dm_we     = r_dm_we;
  assign bus.dm_addr   = r_dm_addr;
  assign bus.dm_wdata  = r_dm_wdata;

endmodule

// File: doc/prog_loader.md
# prog_loader

Host-side load/run/dump controller that sits directly upstream of the processor core. It accepts a byte stream over a valid/ready input, writes an instruction image and a data image into the instruction and data memories, and then drives the processor enable until the core raises finish or a watchdog expires. It then returns a status byte and a window of data memory over a valid/ready output. While the processor is not running, it owns the data-memory port.

## Interface
- RUN_TIMEOUT, 65535: maximum processor run length in cycles (16-bit).
- CLOCK  in  1  system clock; all flops rise-edge.
- RESETN  in  1  asynchronous, active-low reset.
- in_valid  in  1  host byte valid.
- in_data  in  8  host byte.
- in_ready  out  1  block can accept a byte.
- out_valid  out  1  result byte valid.
- out_data  out  8  result byte.
- out_ready  in  1  host consumes the result byte.
- proc_en  out  1  processor EN.
- proc_finish  in  1  processor finish.
- im_we  out  1  instruction-memory write strobe.
- im_waddr  out  8  instruction-memory write address.
- im_wdata  out  8  instruction-memory write data.
- dm_sel  out  1  1 = this block drives the data-memory port; 0 = processor drives it.
- dm_we  out  1  data-memory write strobe.
- dm_addr  out  8  data-memory address.
- dm_wdata  out  8  data-memory write data.
- dm_rdata  in  8  data-memory read data, valid one cycle after dm_addr.

## Operation
- Stream format: im_len, im_len bytes, dm_len, dm_len bytes, dump_len. A length of 0 means no bytes. Maximum length is 255.
- A byte is accepted on any cycle where in_valid and in_ready are both high.
- States and transitions:
  - IDLE: accept im_len. Go to LOAD_IM, or to DM_LEN if im_len = 0.
  - LOAD_IM: each accepted byte is written to IM address 0, 1, 2, … After the last byte, go to DM_LEN.
  - DM_LEN: accept dm_len. Go to LOAD_DM, or to DUMP_LEN if dm_len = 0.
  - LOAD_DM: each accepted byte is written to DM address 0, 1, 2, … After the last byte, go to DUMP_LEN.
  - DUMP_LEN: accept dump_len. Go to RUN.
  - RUN: proc_en = 1, dm_sel = 0, 16-bit cycle counter active. On proc_finish = 1, go to STATUS with code 0x00. When the counter reaches RUN_TIMEOUT, go to STATUS with code 0xEE. If both occur in the same cycle, finish wins.
  - STATUS: present the status byte. Once it is consumed: if code 0x00 and dump_len > 0, go to DUMP_RD; otherwise go to IDLE.
  - DUMP_RD: drive dm_addr = index and wait one cycle for dm_rdata.
  - DUMP_OUT: present the captured byte. Once it is consumed, increment index; go to DUMP_RD if more bytes remain, otherwise IDLE.
- in_ready = 1 only in IDLE, LOAD_IM, DM_LEN, LOAD_DM and DUMP_LEN. It is decoded combinationally from state.
- dm_sel = 0 only in RUN.
- Length and index counters are 8-bit. The address counter resets to 0 on entry to each load phase and to the dump phase.

## Timing
- Reset values: state IDLE; in_ready 1; out_valid 0; out_data 0x00; proc_en 0; im_we 0; im_waddr 0; im_wdata 0; dm_sel 1; dm_we 0; dm_addr 0; dm_wdata 0; all counters 0.
- Memory writes are registered. im_we/dm_we pulse for exactly one cycle, in the cycle after acceptance, with the matching address and data.
- proc_en rises in the cycle after dump_len is accepted. It falls in the cycle after finish is sampled or the timeout is hit.
- A timeout run holds proc_en high for exactly RUN_TIMEOUT cycles.
- out_valid and out_data are registered. Once out_valid is asserted, out_valid and out_data hold stable until out_ready is high.
- Per dumped byte, out_valid rises 2 cycles after entering DUMP_RD. With out_ready tied high, the dump runs at one byte per 3 cycles.
- Reset asserted mid-operation returns everything to reset values immediately. No partial write strobe is emitted, and the next accepted byte is interpreted as im_len.
- proc_finish is ignored outside RUN.
- in_valid is ignored whenever in_ready = 0.

## Test plan
- Load: stream 03 A1 A2 A3 00 00 → im_we pulses at im_waddr 0/1/2 with A1/A2/A3; proc_en rises the cycle after the final 00.
- Run and dump: 00, 02 11 22, 02; memory model; proc_finish pulsed 5 cycles after proc_en rises → dm writes 11@0, 22@1; proc_en high exactly 5 cycles; output 00, 11, 22; then IDLE with in_ready 1.
- Timeout: RUN_TIMEOUT = 8, stream 00 00 04, proc_finish held low → proc_en high exactly 8 cycles; single output byte EE; no dump reads; return to IDLE.
- Back-pressure: dump of 3 bytes with out_ready low for 3 cycles on each byte → out_data stable while stalled; bytes in order; none lost or duplicated.
- Reset mid-load: RESETN low during LOAD_DM after 1 of 4 bytes → all outputs at reset values; next stream 00 00 00 plus finish → output exactly 00.
- Simultaneous finish and timeout: finish arrives in the cycle the counter hits RUN_TIMEOUT → status 00, and the dump proceeds.
